// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_pkg
// Description : Constants and types shared by the convolutional encoder /
//               symbol packer and the Viterbi decoder path.
//               - supported constraint lengths and memory length M = K-1
//               - symbol width and symbols per packed byte
//               - default generator pairs for K = 3, 5, 7
//               - encoder/packer FSM state type
// Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    // Supported constraint lengths
    localparam int c_k_min = 3;
    localparam int c_k_mid = 5;
    localparam int c_k_max = 7;

    // Symbol geometry: one symbol = {g0_bit, g1_bit}, four symbols per byte
    localparam int c_sym_w         = 2;
    localparam int c_syms_per_byte = 4;

    // Default generator pairs (octal)
    localparam int c_g0_k3 = 'o7;
    localparam int c_g1_k3 = 'o5;
    localparam int c_g0_k5 = 'o23;
    localparam int c_g1_k5 = 'o35;
    localparam int c_g0_k7 = 'o171;
    localparam int c_g1_k7 = 'o133;

    // Encoder/packer FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENC   = 3'd1,
        ST_TAIL  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } enc_state_e;

    // True when k is one of the supported constraint lengths
    function automatic bit k_supported(input int k);
        return (k == c_k_min) || (k == c_k_mid) || (k == c_k_max);
    endfunction

    // Encoder memory length (number of tail bits per frame)
    function automatic int mem_len(input int k);
        return k - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// ============================================================================
// Module      : conv_enc_core
// Description : Rate-1/2 feed-forward convolutional encoder core.
//               Register r = {state[K-2:0], bit}; g0 = ^(r & G0),
//               g1 = ^(r & G1); on a step the state shifts in the bit.
//               The symbol output is combinational from the current state
//               and the offered bit so it can be packed in the same cycle.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset
//               i_clear  - zero the shift register (frame start)
//               i_step   - advance the shift register by i_bit
//               i_bit    - bit being encoded this cycle
//               o_sym    - {g0_bit, g1_bit} for i_bit
// Revision    : 1.0 - initial release
// ============================================================================
module conv_enc_core #(
    parameter int K      = 5,
    parameter int G0_OCT = 'o23,
    parameter int G1_OCT = 'o35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_step,
    input  logic       i_bit,
    output logic [1:0] o_sym
);

    localparam int           c_m  = K - 1;
    // Only the K least-significant generator bits take part in the parity
    localparam logic [K-1:0] c_g0 = K'(G0_OCT);
    localparam logic [K-1:0] c_g1 = K'(G1_OCT);

    logic [c_m-1:0] r_state;
    logic [K-1:0]   w_reg;

    // Newest bit sits in bit 0, oldest memory bit in bit K-1
    assign w_reg = {r_state, i_bit};
    assign o_sym = {^(w_reg & c_g0), ^(w_reg & c_g1)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_clear) begin
            r_state <= '0;
        end else if (i_step) begin
            // Dropping the oldest bit is the same as {state[K-3:0], bit}
            r_state <= w_reg[c_m-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_encoder_packer.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder_packer
// Description : Convolutional encoder with symbol packer feeding the Viterbi
//               decoder. Takes payload bytes (bit 0 first), encodes one bit
//               per cycle, appends K-1 zero tail bits and packs four 2-bit
//               symbols per output byte {s3,s2,s1,s0} (s0 earliest). A
//               partial final byte is zero padded. out_last marks the final
//               byte; frame_done pulses one cycle after its handshake.
// Ports       : clk, rst                      - clock, async active-high reset
//               in_data/in_nbits/in_last      - payload byte, valid bits
//                                               (last byte only, 0 => 8), end
//               in_valid/in_ready             - input handshake
//               out_data/out_last             - packed symbols, frame end
//               out_valid/out_ready           - output handshake
//               busy                          - frame in progress
//               frame_done                    - frame completion pulse
//               err_en/err_idx/err_mask       - symbol error injection
//                                               (only with ERR_INJ_EN)
// Options     : ERR_INJ_EN - when defined, adds the error-injection ports;
//               symbol number err_idx of the frame (tail included) is XORed
//               with err_mask before packing while err_en is high.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder_packer
    import viterbi_pkg::*;
#(
    parameter int K      = 5,
    parameter int G0_OCT = 'o23,
    parameter int G1_OCT = 'o35
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic [3:0] in_nbits,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef ERR_INJ_EN
    input  logic       err_en,
    input  logic [7:0] err_idx,
    input  logic [1:0] err_mask,
`endif
    output logic       busy,
    output logic       frame_done
);

    localparam int         c_m         = mem_len(K);
    localparam logic [2:0] c_tail_last = 3'(c_m - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    enc_state_e r_state;
    enc_state_e w_state_nxt;

    logic [7:0] r_byte;        // latched payload, shifted right per bit
    logic [2:0] r_bit_idx;     // bit being encoded within r_byte
    logic [2:0] r_nbits_m1;    // index of the last valid bit of r_byte
    logic       r_last;        // r_byte is the final payload byte
    logic [2:0] r_tail_idx;    // tail bit counter
    logic [7:0] r_pack;        // packing register
    logic [1:0] r_slot;        // next free slot in r_pack
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_out_last;
    logic       r_busy;

    logic       w_in_ready;
    logic       w_accept;
    logic       w_out_free;
    logic       w_step;
    logic       w_bit_last;
    logic       w_tail_last;
    logic       w_push_full;
    logic       w_push_flush;
    logic       w_final_hs;
    logic       w_enc_clear;
    logic       w_enc_bit;
    logic [2:0] w_nbits_m1;
    logic [1:0] w_sym_raw;
    logic [1:0] w_sym;

    // ------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------
    assign w_accept   = in_valid && w_in_ready;

    // Output register can take a new byte if empty or draining this cycle
    assign w_out_free = !r_out_valid || out_ready;

    // A symbol completing the packing register needs the output register;
    // otherwise encoding never waits on the consumer.
    assign w_step = ((r_state == ST_ENC) || (r_state == ST_TAIL)) &&
                    ((r_slot != 2'd3) || w_out_free);

    assign w_bit_last  = (r_bit_idx == r_nbits_m1);
    assign w_tail_last = (r_tail_idx == c_tail_last);

    assign w_push_full  = w_step && (r_slot == 2'd3);
    assign w_push_flush = (r_state == ST_FLUSH) && (r_slot != 2'd0) && w_out_free;

    // Once FLUSH has an empty packing register, the byte holding out_last
    // is the only one left; its handshake ends the frame.
    assign w_final_hs = (r_state == ST_FLUSH) && (r_slot == 2'd0) &&
                        r_out_valid && out_ready && r_out_last;

    // Only the first accept of a frame clears the encoder; later bytes of
    // the same frame continue from the running state.
    assign w_enc_clear = w_accept && !r_busy;
    assign w_enc_bit   = (r_state == ST_ENC) && r_byte[0];

    // in_nbits counts only on the final byte; 0 (and out-of-range) => 8
    always_comb begin
        w_nbits_m1 = 3'd7;
        if (in_last && (in_nbits != 4'd0) && (in_nbits < 4'd8)) begin
            w_nbits_m1 = 3'(in_nbits - 4'd1);
        end
    end

    // ------------------------------------------------------------------
    // Encoder core
    // ------------------------------------------------------------------
    conv_enc_core #(
        .K      (K),
        .G0_OCT (G0_OCT),
        .G1_OCT (G1_OCT)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_enc_clear),
        .i_step  (w_step),
        .i_bit   (w_enc_bit),
        .o_sym   (w_sym_raw)
    );

`ifdef ERR_INJ_EN
    logic [7:0] r_sym_idx;     // frame symbol number of the current step

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym_idx <= 8'd0;
        end else if (w_enc_clear) begin
            r_sym_idx <= 8'd0;
        end else if (w_step) begin
            r_sym_idx <= r_sym_idx + 8'd1;
        end
    end

    assign w_sym = (err_en && (r_sym_idx == err_idx)) ? (w_sym_raw ^ err_mask)
                                                       : w_sym_raw;
`else
    assign w_sym = w_sym_raw;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_ENC;
                end
            end
            ST_ENC: begin
                if (w_step && w_bit_last) begin
                    if (r_last) begin
                        w_state_nxt = ST_TAIL;
                    end else begin
                        // Fetch the next byte on the cycle the last bit is
                        // encoded so a streaming frame has no gap.
                        w_in_ready  = 1'b1;
                        w_state_nxt = in_valid ? ST_ENC : ST_IDLE;
                    end
                end
            end
            ST_TAIL: begin
                if (w_step && w_tail_last) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_final_hs) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input byte and bit/tail counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte     <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_nbits_m1 <= 3'd7;
            r_last     <= 1'b0;
        end else if (w_accept) begin
            r_byte     <= in_data;
            r_bit_idx  <= 3'd0;
            r_nbits_m1 <= w_nbits_m1;
            r_last     <= in_last;
        end else if (w_step && (r_state == ST_ENC)) begin
            r_byte     <= r_byte >> 1;
            r_bit_idx  <= r_bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tail_idx <= 3'd0;
        end else if (w_enc_clear) begin
            r_tail_idx <= 3'd0;
        end else if (w_step && (r_state == ST_TAIL)) begin
            r_tail_idx <= r_tail_idx + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Packing register
    // ------------------------------------------------------------------
    // Cleared when its contents move out, so unused slots of a flushed
    // partial byte are already the 2'b00 pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack <= 8'd0;
            r_slot <= 2'd0;
        end else if (w_push_full || w_push_flush) begin
            r_pack <= 8'd0;
            r_slot <= 2'd0;
        end else if (w_step) begin
            r_pack[{r_slot, 1'b0} +: 2] <= w_sym;
            r_slot                      <= r_slot + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output register and frame tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_push_full) begin
            // The slot-3 symbol bypasses r_pack straight into the byte
            r_out_data  <= {w_sym, r_pack[5:0]};
            r_out_valid <= 1'b1;
            r_out_last  <= (r_state == ST_TAIL) && w_tail_last;
        end else if (w_push_flush) begin
            r_out_data  <= r_pack;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
        end else if (w_final_hs) begin
            r_busy <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign busy       = r_busy;
    assign frame_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_encoder_packer
// Description : Self-checking bench for conv_encoder_packer (K=5, 'o23/'o35).
//               Hand-computed vector table, directed stall/reset sequences
//               and random frames against a reference encoder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_packer;

    localparam int K  = 5;
    localparam int G0 = 'o23;
    localparam int G1 = 'o35;
    localparam int M  = K - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [3:0] in_nbits;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;
    logic       frame_done;
`ifdef ERR_INJ_EN
    logic       err_en   = 1'b0;
    logic [7:0] err_idx  = 8'd0;
    logic [1:0] err_mask = 2'd0;
`endif

    always #5 clk = ~clk;

    conv_encoder_packer #(
        .K      (K),
        .G0_OCT (G0),
        .G1_OCT (G1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_nbits   (in_nbits),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef ERR_INJ_EN
        .err_en     (err_en),
        .err_idx    (err_idx),
        .err_mask   (err_mask),
`endif
        .busy       (busy),
        .frame_done (frame_done)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = 8'd0;
    logic       prev_l = 1'b0;
    int         rdy_mode = 0;      // 0: always ready, 1: random, 2: held low
    int         m_err_idx = -1;
    int         m_err_mask = 0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] nb;
        int         nexp;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;
    vec_t tbl[5];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference encoder: bits -> symbols by the generator parity rule,
    // then four symbols per byte, earliest in the low bits.
    function automatic void model(input logic [7:0] bq[$], input logic [3:0] nb);
        int bits[$];
        int syms[$];
        int st, r, s, n, nbl;
        exp_q.delete();
        nbl = ((nb == 4'd0) || (nb > 4'd8)) ? 8 : int'(nb);
        foreach (bq[i]) begin
            n = (i == bq.size() - 1) ? nbl : 8;
            for (int j = 0; j < n; j++) bits.push_back(int'(bq[i][j]));
        end
        for (int j = 0; j < M; j++) bits.push_back(0);
        st = 0;
        foreach (bits[i]) begin
            r = ((st * 2) + bits[i]) % (1 << K);
            s = 2 * ($countones(r & G0) % 2) + ($countones(r & G1) % 2);
            if (i == m_err_idx) s = s ^ m_err_mask;
            syms.push_back(s);
            st = r % (1 << M);
        end
        for (int i = 0; i < syms.size(); i += 4) begin
            int b;
            b = 0;
            for (int k = 0; k < 4; k++)
                if (i + k < syms.size()) b += syms[i + k] << (2 * k);
            exp_q.push_back(8'(b));
        end
    endfunction

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
            end
            if (frame_done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    // Consumer ready generator
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 0)      out_ready = 1'b1;
            else if (rdy_mode == 2) out_ready = 1'b0;
            else                    out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic [3:0] nb, input logic last);
        int cyc;
        bit ok;
        cyc = 0;
        ok  = 0;
        in_data  = d;
        in_nbits = nb;
        in_last  = last;
        in_valid = 1'b1;
        while (!ok && cyc < 2000) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!ok) chk("in_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bq[$], input logic [3:0] nb);
        foreach (bq[i])
            send_byte(bq[i], (i == bq.size() - 1) ? nb : 4'd8, i == bq.size() - 1);
    endtask

    task automatic wait_done(input string name);
        int c;
        int start;
        c = 0;
        start = done_cnt;
        while (done_cnt == start && c < 5000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, done_cnt - start, 1);
    endtask

    task automatic check_frame(input string name);
        chk({name, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
            chk($sformatf("%s_last%0d", name, i), got_last_q[i], (i == exp_q.size() - 1));
        end
        chk({name, "_busy_end"}, busy, 0);
        got_q.delete();
        got_last_q.delete();
    endtask

    initial begin
        logic [7:0] bq[$];
        logic [3:0] nb;
        int         c;
        int         start;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_nbits = 4'd0;
        in_last  = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Hand-computed single-byte frames (K=5, 'o23/'o35)
        tbl[0] = '{8'h01, 4'd4, 2, 8'h5B, 8'h03, 8'h00};   // final symbol in slot 3
        tbl[1] = '{8'h00, 4'd8, 3, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{8'h01, 4'd1, 2, 8'h5B, 8'h03, 8'h00};   // padded final byte
        tbl[3] = '{8'h01, 4'd0, 3, 8'h5B, 8'h03, 8'h00};   // nbits 0 means 8
        tbl[4] = '{8'h03, 4'd2, 2, 8'h37, 8'h0E, 8'h00};
        for (int i = 0; i < 5; i++) begin
            exp_q.delete();
            exp_q.push_back(tbl[i].e0);
            if (tbl[i].nexp > 1) exp_q.push_back(tbl[i].e1);
            if (tbl[i].nexp > 2) exp_q.push_back(tbl[i].e2);
            send_byte(tbl[i].d, tbl[i].nb, 1'b1);
            chk($sformatf("tbl%0d_busy", i), busy, 1);
            wait_done($sformatf("tbl%0d", i));
            check_frame($sformatf("tbl%0d", i));
        end

        // Two-byte frame against the reference model
        bq = '{8'hE2, 8'hAC};
        model(bq, 4'd8);
        send_frame(bq, 4'd8);
        wait_done("two_byte");
        check_frame("two_byte");

        // Consumer stall right after the first byte appears
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h01, 4'd4, 1'b1);
        c = 0;
        while (!out_valid && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("stall_first_valid", out_valid, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_hold_data", out_data, 8'h5B);
        chk("stall_busy", busy, 1);
        rdy_mode = 0;
        exp_q = '{8'h5B, 8'h03};
        wait_done("stall");
        check_frame("stall");

        // Reset in the middle of encoding
        send_byte(8'h01, 4'd8, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        got_last_q.delete();
        start = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt - start, 0);
        chk("midrst_no_output", got_q.size(), 0);
        exp_q = '{8'h5B, 8'h03};
        send_byte(8'h01, 4'd4, 1'b1);
        wait_done("after_rst");
        check_frame("after_rst");

`ifdef ERR_INJ_EN
        // Flip the low bit of symbol 0
        err_en     = 1'b1;
        err_idx    = 8'd0;
        err_mask   = 2'b01;
        exp_q      = '{8'h5A, 8'h03};
        send_byte(8'h01, 4'd4, 1'b1);
        wait_done("err_inj");
        check_frame("err_inj");
        err_en     = 1'b0;
`endif

        // Random frames with a random consumer
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            bq.delete();
            for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                bq.push_back(8'($urandom));
            nb = 4'($urandom_range(1, 8));
`ifdef ERR_INJ_EN
            if (f % 3 == 0) begin
                err_en     = 1'b1;
                err_idx    = 8'($urandom_range(0, 12));
                err_mask   = 2'($urandom_range(1, 3));
                m_err_idx  = int'(err_idx);
                m_err_mask = int'(err_mask);
            end else begin
                err_en     = 1'b0;
                m_err_idx  = -1;
            end
`endif
            model(bq, nb);
            send_frame(bq, nb);
            wait_done($sformatf("rand%0d", f));
            check_frame($sformatf("rand%0d", f));
        end
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
